rob_ctrl: RTL and testbench

Sequencing controller for the reorder buffer: owns the head/tail pointers, the occupancy count and the per-entry valid bitmap for a bank of DEPTH ROB lines. It grants in-order allocation to dispatch and routes out-of-order completion updates to the addressed line. It presents in-order commits to the retire stage and drives a one-cycle flush when an excepting entry commits. The line storage sits outside this block; rob_ctrl only produces per-line strobes and consumes per-line done flags.

---
 rtl/rob_ctrl.sv | 143 ++++++++++++++
 tb/tb_rob_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_ctrl.sv
// -----------------------------------------------------------------------------
// rob_ctrl
//
// Sequencing controller for a reorder buffer of DEPTH lines. It owns the
// head/tail pointers, the occupancy count and the per-line valid bitmap, and it
// exchanges per-line strobes and done flags with line storage held elsewhere.
//
//   Allocation: dispatch gets in-order entries at the tail.
//   Update:     out-of-order completions are routed to the addressed line.
//   Commit:     in-order commits are offered to retire from the head.
//   Flush:      a committing entry with an exception starts a one-cycle flush.
//
// Ports
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   alloc_req       dispatch wants one entry this cycle
//   alloc_ready     an entry can be allocated this cycle
//   alloc_idx       index being allocated (tail)
//   line_write_en   one-hot write strobe to line alloc_idx (fire cycle only)
//   update_en       completion update for update_idx
//   update_idx      line being completed
//   line_update_en  one-hot update strobe; dropped for invalid lines or in flush
//   line_done       done flag of each line, read back from the storage
//   head_exc        exception type of the head line is non-zero
//   commit_ready    retire stage accepts a commit
//   commit_valid    head entry is valid and done
//   commit_idx      index of the head entry
//   flush           one-cycle flush pulse, taken from the registered state
//   count           number of valid entries
//   empty, full     count == 0 / count == DEPTH
// -----------------------------------------------------------------------------
module rob_ctrl #(
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alloc_req,
   output logic                  alloc_ready,
   output logic [ADDR_WIDTH-1:0] alloc_idx,
   output logic [DEPTH-1:0]      line_write_en,
   input  logic                  update_en,
   input  logic [ADDR_WIDTH-1:0] update_idx,
   output logic [DEPTH-1:0]      line_update_en,
   input  logic [DEPTH-1:0]      line_done,
   input  logic                  head_exc,
   input  logic                  commit_ready,
   output logic                  commit_valid,
   output logic [ADDR_WIDTH-1:0] commit_idx,
   output logic                  flush,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  empty,
   output logic                  full
);

   typedef enum logic {RUN, FLUSH} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] head, head_nxt;
   logic [ADDR_WIDTH-1:0] tail, tail_nxt;
   logic [ADDR_WIDTH:0]   count_nxt;
   logic [DEPTH-1:0]      valid, valid_nxt;
   logic                  run, alloc_fire, commit_fire;

   assign alloc_idx  = tail;
   assign commit_idx = head;
   assign flush      = (state == FLUSH);
   assign empty      = (count == '0);
   assign full       = (count == (ADDR_WIDTH+1)'(DEPTH));

   // NOTE: the register block uses non-blocking assignments so every flop
   // samples the pre-edge values computed below; blocking here would let later
   // statements see already-updated state and break the pointer arithmetic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: valid is a small flop bitmap, not line storage, so it is reset
         // with the rest of the state; the line contents themselves are left
         // alone and any stale done flag is masked by valid.
         state <= RUN;
         head  <= '0;
         tail  <= '0;
         count <= '0;
         valid <= '0;
      end else begin
         state <= state_nxt;
         head  <= head_nxt;
         tail  <= tail_nxt;
         count <= count_nxt;
         valid <= valid_nxt;
      end
   end

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_nxt      = state;
      head_nxt       = head;
      tail_nxt       = tail;
      count_nxt      = count;
      valid_nxt      = valid;
      line_write_en  = '0;
      line_update_en = '0;

      // Outputs are gated by rst so the handshakes stay quiet while reset is
      // held, even though the state flops already read RUN.
      run          = (state == RUN) && !rst;
      alloc_ready  = run && !full;
      alloc_fire   = alloc_req && alloc_ready;
      commit_valid = run && valid[head] && line_done[head];
      commit_fire  = commit_valid && commit_ready;

      // The write strobe fires even when a same-cycle exception commit
      // discards the allocation; that line simply never becomes valid.
      if (alloc_fire)
         line_write_en = DEPTH'(1) << tail;
      if (update_en && run && valid[update_idx])
         line_update_en = DEPTH'(1) << update_idx;

      if (state == FLUSH) begin
         state_nxt = RUN;
      end else if (commit_fire && head_exc) begin
         state_nxt = FLUSH;
         head_nxt  = '0;
         tail_nxt  = '0;
         count_nxt = '0;
         valid_nxt = '0;
      end else begin
         // Clear before set: with DEPTH >= 2 and a non-full buffer, head and
         // tail never coincide on a valid entry, so order only matters for
         // readability.
         if (commit_fire) begin
            valid_nxt[head] = 1'b0;
            head_nxt        = head + 1'b1;
         end
         if (alloc_fire) begin
            valid_nxt[tail] = 1'b1;
            tail_nxt        = tail + 1'b1;
         end
         count_nxt = count + (ADDR_WIDTH+1)'(alloc_fire)
                           - (ADDR_WIDTH+1)'(commit_fire);
      end
   end

endmodule

// File: tb/tb_rob_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rob_ctrl
//
// Directed bench for rob_ctrl with DEPTH=4. The bench plays the line storage:
// it raises line_done for a line the cycle after updating it and clears it the
// cycle after allocating it. Inputs change 1 ns after a rising edge and the
// outputs are compared 1 ns later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_rob_ctrl;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk;
   logic          rst;
   logic          alloc_req;
   logic          alloc_ready;
   logic [AW-1:0] alloc_idx;
   logic [DEPTH-1:0] line_write_en;
   logic          update_en;
   logic [AW-1:0] update_idx;
   logic [DEPTH-1:0] line_update_en;
   logic [DEPTH-1:0] line_done;
   logic          head_exc;
   logic          commit_ready;
   logic          commit_valid;
   logic [AW-1:0] commit_idx;
   logic          flush;
   logic [AW:0]   count;
   logic          empty;
   logic          full;

   int n_checks = 0;
   int n_fails  = 0;

   rob_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk            (clk),
      .rst            (rst),
      .alloc_req      (alloc_req),
      .alloc_ready    (alloc_ready),
      .alloc_idx      (alloc_idx),
      .line_write_en  (line_write_en),
      .update_en      (update_en),
      .update_idx     (update_idx),
      .line_update_en (line_update_en),
      .line_done      (line_done),
      .head_exc       (head_exc),
      .commit_ready   (commit_ready),
      .commit_valid   (commit_valid),
      .commit_idx     (commit_idx),
      .flush          (flush),
      .count          (count),
      .empty          (empty),
      .full           (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int h;
      int t;

      rst          = 1'b1;
      alloc_req    = 1'b0;
      update_en    = 1'b0;
      update_idx   = '0;
      line_done    = '0;
      head_exc     = 1'b0;
      commit_ready = 1'b0;

      // ---------------- reset ----------------
      #2;
      check("rst_alloc_ready", alloc_ready, 0);
      check("rst_commit_valid", commit_valid, 0);
      check("rst_flush", flush, 0);
      alloc_req = 1'b1;
      #1;
      check("rst_write_en", line_write_en, 0);
      alloc_req = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("post_rst_empty", empty, 1);
      check("post_rst_full", full, 0);
      check("post_rst_count", count, 0);
      check("post_rst_alloc_idx", alloc_idx, 0);
      check("post_rst_commit_idx", commit_idx, 0);
      check("post_rst_alloc_ready", alloc_ready, 1);

      // ---------------- fill ----------------
      for (int i = 0; i < DEPTH; i++) begin
         alloc_req = 1'b1;
         #1;
         check("fill_alloc_idx", alloc_idx, i);
         check("fill_write_en", line_write_en, 32'd1 << i);
         tick();
      end
      #1;
      check("full_flag", full, 1);
      check("full_count", count, 4);
      check("full_alloc_ready", alloc_ready, 0);
      check("full_5th_strobe", line_write_en, 0);
      tick();
      check("full_count_hold", count, 4);
      alloc_req = 1'b0;

      // ---------------- out-of-order completion ----------------
      commit_ready = 1'b1;
      update_en    = 1'b1;
      update_idx   = 2'd2;
      #1;
      check("ooo_upd2_strobe", line_update_en, 4'b0100);
      check("ooo_no_commit_a", commit_valid, 0);
      tick();
      line_done[2] = 1'b1;
      update_idx   = 2'd0;
      #1;
      check("ooo_upd0_strobe", line_update_en, 4'b0001);
      check("ooo_no_commit_b", commit_valid, 0);
      tick();
      line_done[0] = 1'b1;
      update_idx   = 2'd1;
      #1;
      check("ooo_upd1_strobe", line_update_en, 4'b0010);
      check("ooo_commit0_valid", commit_valid, 1);
      check("ooo_commit0_idx", commit_idx, 0);
      tick();
      line_done[1] = 1'b1;
      update_en    = 1'b0;
      #1;
      check("ooo_count3", count, 3);
      check("ooo_commit1_idx", commit_idx, 1);
      check("ooo_commit1_valid", commit_valid, 1);
      tick();
      check("ooo_commit2_idx", commit_idx, 2);
      check("ooo_commit2_valid", commit_valid, 1);
      tick();
      check("ooo_count1", count, 1);
      check("ooo_head3_not_done", commit_valid, 0);

      // ---------------- update to an unallocated line ----------------
      update_en  = 1'b1;
      update_idx = 2'd1;
      #1;
      check("inv_upd_strobe", line_update_en, 0);
      tick();
      update_en = 1'b0;
      #1;
      check("inv_upd_count", count, 1);
      check("inv_upd_commit_valid", commit_valid, 0);
      check("inv_upd_alloc_idx", alloc_idx, 0);

      // ---------------- simultaneous alloc and commit ----------------
      // Allocate line 0 and complete line 3 to reach count=2 with head done.
      alloc_req  = 1'b1;
      update_en  = 1'b1;
      update_idx = 2'd3;
      #1;
      check("pre_sim_upd3_strobe", line_update_en, 4'b1000);
      tick();
      line_done[3] = 1'b1;
      line_done[0] = 1'b0;
      h = 3;
      t = 1;
      for (int k = 0; k < 6; k++) begin
         update_idx = 2'((h + 1) % DEPTH);
         #1;
         check("sim_count", count, 2);
         check("sim_commit_valid", commit_valid, 1);
         check("sim_commit_idx", commit_idx, h);
         check("sim_alloc_idx", alloc_idx, t);
         tick();
         line_done[(h + 1) % DEPTH] = 1'b1;
         line_done[t]               = 1'b0;
         h = (h + 1) % DEPTH;
         t = (t + 1) % DEPTH;
      end
      update_en    = 1'b0;
      commit_ready = 1'b0;
      #1;
      check("sim_end_count", count, 2);
      check("sim_end_commit_idx", commit_idx, 1);
      check("sim_end_alloc_idx", alloc_idx, 3);

      // ---------------- exception commit ----------------
      tick();
      line_done[3] = 1'b0;
      check("exc_pre_count", count, 3);
      head_exc     = 1'b1;
      commit_ready = 1'b1;
      #1;
      check("exc_commit_valid", commit_valid, 1);
      check("exc_commit_idx", commit_idx, 1);
      check("exc_alloc_strobe", line_write_en, 4'b0001);
      tick();
      head_exc   = 1'b0;
      update_en  = 1'b1;
      update_idx = 2'd2;
      #1;
      check("exc_flush", flush, 1);
      check("exc_flush_alloc_ready", alloc_ready, 0);
      check("exc_flush_commit_valid", commit_valid, 0);
      check("exc_flush_upd_strobe", line_update_en, 0);
      check("exc_flush_count", count, 0);
      tick();
      update_en = 1'b0;
      alloc_req = 1'b0;
      #1;
      check("exc_after_flush", flush, 0);
      check("exc_after_alloc_ready", alloc_ready, 1);
      check("exc_after_alloc_idx", alloc_idx, 0);
      check("exc_after_count", count, 0);
      check("exc_after_commit_valid", commit_valid, 0);

      // ---------------- async reset mid-operation ----------------
      line_done    = '0;
      commit_ready = 1'b0;
      alloc_req    = 1'b1;
      tick();
      tick();
      tick();
      check("arst_pre_count", count, 3);
      #1;
      rst = 1'b1;
      #1;
      check("arst_count", count, 0);
      check("arst_empty", empty, 1);
      check("arst_alloc_ready", alloc_ready, 0);
      check("arst_write_en", line_write_en, 0);
      check("arst_alloc_idx", alloc_idx, 0);
      check("arst_flush", flush, 0);
      alloc_req = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      check("arst_flush_after", flush, 0);
      check("arst_count_after", count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
